cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-result common data bus (CDB) among execution units (ALU, Load, Store, ...).
//  Each requester owns a one-entry holding slot. One granted slot is broadcast per cycle as (valid, lock index, result)
//    to ROB, PC and reservation stations.
//  Sits between the execution units and the CDB broadcast fan-out; replaces fixed-ALU wiring as units are added.
// PARAMETERS
//  NUM_REQ     3   number of requesting units (>=2); requester 0 = ALU, 1 = Load, 2 = Store
//  LOCK_WIDTH  4   width of ROB lock/entry index (matches Reg_Lock_Width)
//  DATA_WIDTH  32  result width (matches Data_Width)
// PORTS
//  clk         in   1                     clock, all state on rising edge
//  rst         in   1                     synchronous reset, active-high
//  flush       in   1                     mispredict flush: drop all held and in-flight results
//  req_valid   in   NUM_REQ               per-requester result offered
//  req_index   in   NUM_REQ*LOCK_WIDTH    per-requester lock index, requester i at [i*LOCK_WIDTH +: LOCK_WIDTH]
//  req_result  in   NUM_REQ*DATA_WIDTH    per-requester result, same packing
//  req_ready   out  NUM_REQ               slot i can accept this cycle (combinational)
//  cdb_valid   out  1                     broadcast valid (registered)
//  cdb_index   out  LOCK_WIDTH            broadcast lock index
//  cdb_result  out  DATA_WIDTH            broadcast result
//  cdb_src     out  $clog2(NUM_REQ)       requester number that produced the broadcast
// BEHAVIOUR
//  Reset: all slots empty; rr_ptr=0; cdb_valid=0; cdb_index=0; cdb_result=0; cdb_src=0.
//    req_ready=all ones in the cycle after reset.
//  Handshake: transfer on edge where req_valid[i] && req_ready[i]; the data is latched into slot i.
//    req_ready[i] = !slot_full[i] || grant[i] (slot freed by grant the same cycle may be reloaded).
//    req_ready has no dependence on req_valid.
//  Grant (combinational): scan full slots starting at rr_ptr, ascending, wrapping at NUM_REQ-1 -> 0.
//    The first full slot is granted. At most one grant per cycle.
//  On grant of slot g at edge:
//    cdb_valid<=1, cdb_index/cdb_result<=slot g contents, cdb_src<=g.
//    Slot g is emptied, unless reloaded the same edge.
//    rr_ptr<=(g==NUM_REQ-1)?0:g+1.
//  No grant: cdb_valid<=0; cdb_index/cdb_result/cdb_src hold their last values; rr_ptr unchanged.
//  Latency: result accepted at edge k with the arbiter otherwise idle appears on the CDB during cycle after edge k+1.
//    cdb_valid is held exactly one cycle per grant.
//  Lock index 0 means "no destination": the slot accepts the result but does not fill; the result is never broadcast.
//  Fairness: a full slot is granted within NUM_REQ cycles of filling.
//  flush (edge, no rst): all slots emptied, cdb_valid<=0, rr_ptr unchanged.
//    Requests presented the same cycle are dropped; req_ready stays per the rule above.
//  rst overrides flush. Reset mid-burst discards all held results; no partial broadcast.
// TESTING
//  1. Single ALU result idx=5, data=0xDEADBEEF at edge k -> cdb_valid=1, idx=5, data=0xDEADBEEF, src=0
//     in cycle after edge k+1 only.
//  2. All 3 slots filled same edge with idx 1,2,3 -> broadcasts in consecutive cycles, src order 0,1,2;
//     rr_ptr ends at 0.
//  3. Requester 0 valid every cycle, 1 and 2 held full -> src order 0,1,2,0,1,2; no slot waits more than 3 cycles.
//  4. Request with idx=0, data=0x1234 -> req_ready stays 1, cdb_valid never asserts.
//  5. Slots 1,2 full, flush asserted with new req on 0 -> next cycle cdb_valid=0, all slots empty,
//     nothing broadcast afterwards.
//  6. rst pulsed while 2 slots full and cdb_valid=1 -> next cycle all outputs zero, req_ready=3'b111, rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the execution units and the CDB arbiter.
// The arbiter takes the slave view; the units and broadcast consumers take the master view.
interface cdb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int LOCK_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*LOCK_WIDTH-1:0] req_index;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_result;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          cdb_valid;
    logic [LOCK_WIDTH-1:0]         cdb_index;
    logic [DATA_WIDTH-1:0]         cdb_result;
    logic [SRC_W-1:0]              cdb_src;

    modport master (
        output req_valid, req_index, req_result,
        input  req_ready, cdb_valid, cdb_index, cdb_result, cdb_src
    );

    modport slave (
        input  req_valid, req_index, req_result,
        output req_ready, cdb_valid, cdb_index, cdb_result, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one holding slot per execution unit,
// one registered broadcast per cycle.
module cdb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int LOCK_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int          SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U = NUM_REQ;
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    slot_full;
    logic [LOCK_WIDTH-1:0] slot_index  [NUM_REQ];
    logic [DATA_WIDTH-1:0] slot_result [NUM_REQ];
    logic [SRC_W-1:0]      rr_ptr;

    logic [NUM_REQ-1:0]    grant;
    logic [SRC_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    ready;

    logic                  cdb_valid_q;
    logic [LOCK_WIDTH-1:0] cdb_index_q;
    logic [DATA_WIDTH-1:0] cdb_result_q;
    logic [SRC_W-1:0]      cdb_src_q;

    // Scan full slots starting at rr_ptr, wrapping; the first hit wins.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned off = 0; off < NREQ_U; off++) begin
            cand = 32'(rr_ptr) + off;
            if (cand >= NREQ_U) begin
                cand = cand - NREQ_U;
            end
            if (!grant_any && slot_full[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    // A slot being granted this cycle may be reloaded at the same edge.
    assign ready = ~slot_full | grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full    <= '0;
            rr_ptr       <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_index_q  <= '0;
            cdb_result_q <= '0;
            cdb_src_q    <= '0;
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                slot_index[i]  <= '0;
                slot_result[i] <= '0;
            end
        end else if (flush) begin
            slot_full   <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_index_q  <= slot_index[grant_idx];
                cdb_result_q <= slot_result[grant_idx];
                cdb_src_q    <= grant_idx;
                rr_ptr       <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
            end
            // Lock index 0 completes the handshake but leaves the slot empty.
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                if (bus.req_valid[i] && ready[i]) begin
                    slot_index[i]  <= bus.req_index[i*LOCK_WIDTH +: LOCK_WIDTH];
                    slot_result[i] <= bus.req_result[i*DATA_WIDTH +: DATA_WIDTH];
                    slot_full[i]   <= (bus.req_index[i*LOCK_WIDTH +: LOCK_WIDTH] != '0);
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_index  = cdb_index_q;
    assign bus.cdb_result = cdb_result_q;
    assign bus.cdb_src    = cdb_src_q;
endmodule
